// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer/arbiter.
// Holds the opcode encoding and the FSM state encoding used by
// alu_seq_arbiter and alu_iter_core.
package alu_pkg;

  // Opcode encoding carried on reqN_op
  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  // Sequencer states
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative MUL/DIV engine: shift-add multiply and restoring divide,
// one bit per cycle over W cycles.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        load operands and begin a new operation (one cycle pulse)
//   op           MUL or DIV (only op==DIV selects divide)
//   a, b         operands (a = multiplicand/dividend, b = multiplier/divisor)
//   done         high from the end of the last iteration until next start
//   result       low W bits of product, or unsigned quotient
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int unsigned CW = $clog2(W) + 1;

  logic          run_q, run_d;
  logic          done_q, done_d;
  logic          div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // acc: product high half (MUL) or partial remainder (DIV)
  logic [W-1:0]  acc_q, acc_d;
  // mq: multiplier shifting out / product low half (MUL), dividend -> quotient (DIV)
  logic [W-1:0]  mq_q, mq_d;
  logic [W-1:0]  b_q, b_d;

  logic [W:0]    mul_sum;
  logic [W:0]    div_sh;
  logic          div_ge;
  logic [W-1:0]  div_rem;

  // One iteration step plus start/stop control
  always_comb begin
    run_d  = run_q;
    done_d = done_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    mq_d   = mq_q;
    b_d    = b_q;

    mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
    div_sh  = {acc_q, mq_q[W-1]};
    div_ge  = (div_sh >= {1'b0, b_q});
    // When div_ge the true difference is below 2^W, so W bits suffice
    div_rem = div_sh[W-1:0] - b_q;

    if (start) begin
      run_d  = 1'b1;
      done_d = 1'b0;
      div_d  = (op == DIV);
      cnt_d  = '0;
      acc_d  = '0;
      mq_d   = a;
      b_d    = b;
    end else if (run_q) begin
      if (div_q) begin
        acc_d = div_ge ? div_rem : div_sh[W-1:0];
        mq_d  = {mq_q[W-2:0], div_ge};
      end else begin
        acc_d = mul_sum[W:1];
        mq_d  = {mul_sum[0], mq_q[W-1:1]};
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      mq_q   <= '0;
      b_q    <= '0;
    end else begin
      run_q  <= run_d;
      done_q <= done_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      mq_q   <= mq_d;
      b_q    <= b_d;
    end
  end

  assign done   = done_q;
  assign result = mq_q;

endmodule

// File: rtl/alu_seq_arbiter.sv
// Round-robin arbiter sharing one 4-function ALU between two requesters.
// ADD/SUB/DIV-by-zero resolve in one cycle; MUL/DIV use alu_iter_core.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b (N=0,1)   requester handshake and operation
//   res_valid/ready                   result handshake
//   res_data, res_id, res_err         result, issuing requester, div-by-zero
//   busy                              sequencer not idle
module alu_seq_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_id,
  output logic         res_err,
  output logic         busy
);

  state_t       state_q, state_d;
  logic         rr_q, rr_d;          // 1: requester 1 favoured on contention
  logic [1:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         id_q, id_d;
  logic         res_valid_q, res_valid_d;
  logic [W-1:0] res_data_q, res_data_d;
  logic         res_id_q, res_id_d;
  logic         res_err_q, res_err_d;
  logic         busy_q, busy_d;

  logic         idle_c, gnt0_c, gnt1_c, accept_c, iter_c;
  logic [1:0]   sel_op_c;
  logic [W-1:0] sel_a_c, sel_b_c;
  logic [W-1:0] quick_c;
  logic         core_done;
  logic [W-1:0] core_result;

  // Round-robin grant; ready only while idle
  assign idle_c     = (state_q == IDLE);
  assign gnt1_c     = req1_valid && (!req0_valid || rr_q);
  assign gnt0_c     = req0_valid && !gnt1_c;
  assign req0_ready = idle_c && gnt0_c;
  assign req1_ready = idle_c && gnt1_c;
  assign accept_c   = req0_ready || req1_ready;

  assign sel_op_c = gnt1_c ? req1_op : req0_op;
  assign sel_a_c  = gnt1_c ? req1_a  : req0_a;
  assign sel_b_c  = gnt1_c ? req1_b  : req0_b;
  // Division by zero skips the iterative engine
  assign iter_c   = (sel_op_c == MUL) || ((sel_op_c == DIV) && (sel_b_c != '0));

  alu_iter_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (accept_c && iter_c),
    .op     (sel_op_c),
    .a      (sel_a_c),
    .b      (sel_b_c),
    .done   (core_done),
    .result (core_result)
  );

  // Single-cycle results; only DIV-by-zero reaches the default arm
  always_comb begin
    quick_c = '1;
    case (op_q)
      ADD:     quick_c = a_q + b_q;
      SUB:     quick_c = a_q - b_q;
      default: quick_c = '1;
    endcase
  end

  // Sequencer next state and result register updates
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_err_d   = res_err_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          op_d    = sel_op_c;
          a_d     = sel_a_c;
          b_d     = sel_b_c;
          id_d    = gnt1_c;
          rr_d    = gnt0_c;
          state_d = iter_c ? EXEC : DONE;
        end
      end
      EXEC: begin
        if (core_done) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_data_d  = core_result;
          res_id_d    = id_q;
          res_err_d   = 1'b0;
        end
      end
      DONE: begin
        // First DONE cycle of a single-cycle op registers its result
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_data_d  = quick_c;
          res_id_d    = id_q;
          res_err_d   = (op_q == DIV);
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      op_q        <= ADD;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq_arbiter.sv
// Self-checking bench for alu_seq_arbiter: directed cases, contention,
// backpressure, reset abort and a randomized mix against a reference model.
module tb_alu_seq_arbiter;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready, res_id, res_err, busy;
  logic [W-1:0] res_data;

  alu_seq_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_err    (res_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } req_t;

  req_t q0[$];
  req_t q1[$];
  int   grant_log[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           fav;          // requester favoured on contention
  bit           outstanding;  // an accepted op has not yet been handed off
  int           cyc;          // edges since the accepting edge
  int           exp_lat;
  logic [W-1:0] exp_data;
  logic         exp_id, exp_err;
  int           vcnt;         // cycles the current result has been held
  logic [W-1:0] last_data;
  logic         last_id, last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic straight from the operation definitions
  function automatic void ref_op(input req_t r, output logic [W-1:0] d,
                                 output logic e, output int lat);
    int unsigned ai, bi;
    ai  = 32'(r.a);
    bi  = 32'(r.b);
    e   = 1'b0;
    lat = 1;
    d   = '0;
    case (r.op)
      ADD: d = W'(ai + bi);
      SUB: d = W'(ai - bi);
      MUL: begin d = W'(ai * bi); lat = W + 1; end
      default: begin
        if (bi == 0) begin d = '1; e = 1'b1; end
        else begin d = W'(ai / bi); lat = W + 1; end
      end
    endcase
  endfunction

  task automatic push(input int who, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    if (who == 0) q0.push_back(r); else q1.push_back(r);
  endtask

  function automatic void model_reset();
    fav = 0; outstanding = 1'b0; cyc = 0; exp_lat = 1; vcnt = 0;
  endfunction

  // Drive both queues through the DUT; mode 0: res_ready=1, 1: random,
  // 2: hold each result for 5 cycles before accepting it.
  task automatic run(input int mode, input bit gate, input int budget);
    int   n;
    bit   v0, v1, rdy, er0, er1, have_res;
    int   g;
    req_t r;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || outstanding) && n < budget) begin
      v0 = (q0.size() > 0) && (!gate || $urandom_range(0, 3) != 0);
      v1 = (q1.size() > 0) && (!gate || $urandom_range(0, 3) != 0);
      req0_valid = v0;
      req1_valid = v1;
      if (q0.size() > 0) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
      else begin req0_op = 2'($urandom); req0_a = W'($urandom); req0_b = W'($urandom); end
      if (q1.size() > 0) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
      else begin req1_op = 2'($urandom); req1_a = W'($urandom); req1_b = W'($urandom); end
      have_res = outstanding && (cyc >= exp_lat);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 1) != 0);
        default: rdy = have_res && (vcnt >= 5);
      endcase
      res_ready = rdy;
      #1;
      g   = (v0 && v1) ? fav : (v0 ? 0 : 1);
      er0 = !outstanding && v0 && (g == 0);
      er1 = !outstanding && v1 && (g == 1);
      chk("ready_both", 32'(req0_ready & req1_ready), 32'(0));
      chk("req0_ready", 32'(req0_ready), 32'(er0));
      chk("req1_ready", 32'(req1_ready), 32'(er1));
      chk("busy", 32'(busy), 32'(outstanding));
      chk("res_valid", 32'(res_valid), 32'(have_res));
      if (have_res) begin
        chk("res_data", 32'(res_data), 32'(exp_data));
        chk("res_id", 32'(res_id), 32'(exp_id));
        chk("res_err", 32'(res_err), 32'(exp_err));
      end
      if (er0 || er1) begin
        r = er0 ? q0.pop_front() : q1.pop_front();
        ref_op(r, exp_data, exp_err, exp_lat);
        exp_id = er1;
        grant_log.push_back(er1 ? 1 : 0);
        fav = er1 ? 0 : 1;
        outstanding = 1'b1;
        cyc = 0;
        vcnt = 0;
      end else if (have_res && rdy) begin
        last_data = exp_data; last_id = exp_id; last_err = exp_err;
        outstanding = 1'b0;
        vcnt = 0;
      end else if (outstanding) begin
        cyc++;
        if (have_res) vcnt++;
      end
      @(posedge clk); #1;
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("run_budget", 32'(n < budget), 32'(1));
  endtask

  initial begin
    int k;
    req0_valid = 1'b0; req0_op = ADD; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = ADD; req1_a = '0; req1_b = '0;
    res_ready  = 1'b0;
    last_data = '0; last_id = 1'b0; last_err = 1'b0;
    exp_data = '0; exp_id = 1'b0; exp_err = 1'b0;
    model_reset();

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'(0));
    chk("rst_res_data", 32'(res_data), 32'(0));
    chk("rst_res_id", 32'(res_id), 32'(0));
    chk("rst_res_err", 32'(res_err), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed single operations
    push(0, ADD, 8'hF0, 8'h20); run(0, 0, 200);
    chk("add_data", 32'(last_data), 32'h10);
    chk("add_id", 32'(last_id), 32'(0));
    chk("add_err", 32'(last_err), 32'(0));
    push(0, SUB, 8'h00, 8'h01); run(0, 0, 200);
    chk("sub_data", 32'(last_data), 32'hFF);
    push(1, MUL, 8'h0F, 8'h11); run(0, 0, 200);
    chk("mul_data", 32'(last_data), 32'hFF);
    chk("mul_id", 32'(last_id), 32'(1));
    push(1, DIV, 8'd200, 8'd7); run(0, 0, 200);
    chk("div_data", 32'(last_data), 32'h1C);
    chk("div_id", 32'(last_id), 32'(1));
    push(0, DIV, 8'h55, 8'h00); run(0, 0, 200);
    chk("div0_data", 32'(last_data), 32'hFF);
    chk("div0_err", 32'(last_err), 32'(1));

    // Reset in the middle of a MUL aborts it
    req0_valid = 1'b1; req0_op = MUL; req0_a = 8'h33; req0_b = 8'h05;
    #1;
    k = 0;
    while (!req0_ready && k < 10) begin @(posedge clk); #1; k++; end
    chk("rstmid_ready", 32'(req0_ready), 32'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_busy_before", 32'(busy), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("rstmid_res_valid", 32'(res_valid), 32'(0));
    chk("rstmid_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("rstmid_no_result", 32'(res_valid), 32'(0));
      chk("rstmid_idle", 32'(busy), 32'(0));
    end
    push(1, ADD, 8'h12, 8'h34); run(0, 0, 200);
    chk("post_rst_data", 32'(last_data), 32'h46);
    chk("post_rst_id", 32'(last_id), 32'(1));

    // Contention: pointer favours requester 0 after the reset above
    grant_log.delete();
    push(0, ADD, 8'h01, 8'h02); push(1, MUL, 8'h07, 8'h09);
    push(0, DIV, 8'hFE, 8'h03); push(1, SUB, 8'h10, 8'h20);
    push(0, MUL, 8'hAB, 8'hCD); push(1, DIV, 8'h40, 8'h00);
    push(0, SUB, 8'h80, 8'h7F); push(1, ADD, 8'hFF, 8'hFF);
    run(0, 0, 500);
    chk("contention_count", 32'(grant_log.size()), 32'(8));
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      chk("contention_grant", 32'(grant_log[i]), 32'(i % 2));

    // Backpressure: each result held 5 cycles, next accept right after
    push(0, ADD, 8'h11, 8'h22); push(1, SUB, 8'h05, 8'h09); push(0, MUL, 8'h13, 8'h0B);
    run(2, 0, 500);

    // Randomized mix with random valid gaps and random res_ready
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      push(int'($urandom_range(0, 1)), 2'($urandom), W'($urandom), rb);
    end
    run(1, 1, 5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_arbiter.md
Name: alu_seq_arbiter

Overview:
- Shares one 4-function 8-bit ALU engine between two requesters using round-robin arbitration with valid/ready handshakes.
- Sequences the engine: ADD/SUB finish in a single cycle; MUL and DIV run iteratively (shift-add and restoring divide) over W cycles.
- Sits between the requesting datapath blocks and the result consumer.
- Each result is returned tagged with the index of the requester that issued it.

Parameters:
- W, 8, operand/result width; also the MUL/DIV iteration count.
- CW, $clog2(W)+1, iteration counter width (derived; not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  opcode: ADD=00, SUB=01, MUL=10, DIV=11.
- req0_a, req0_b  in  W  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  W  result.
- res_id  out  1  index of the requester that issued the operation.
- res_err  out  1  divide-by-zero flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, active-high) forces: state=IDLE; res_valid=0; res_data=0; res_id=0; res_err=0; busy=0; RR pointer favours requester 0; iteration counter=0.
- Clock and reset share one domain: single clock, reset asynchronous and active-high.
- Reset asserted mid-operation aborts the operation. No result is produced, and the operation is not replayed.
- States and transitions:
  - IDLE -> EXEC on accepting MUL or DIV with b!=0.
  - IDLE -> DONE on accepting ADD, SUB, or DIV with b==0.
  - EXEC -> DONE after W iterations.
  - DONE -> IDLE when res_valid && res_ready.
- Arbitration:
  - reqN_ready is combinational: high only in IDLE, and only for the granted requester. Never both high in one cycle.
  - If one requester is valid, it is granted.
  - If both are valid, the requester favoured by the pointer is granted. After each accept the pointer moves to favour the other requester.
  - ready does not depend on res_ready.
  - Operands and opcode are captured at the accepting edge. Requester inputs are don't-care afterwards.
- Latency, counted from the accepting edge T:
  - ADD/SUB/DIV-by-zero: res_valid high after edge T+1.
  - MUL/DIV: res_valid high after edge T+W+1.
- Result stall: res_valid stays high, and res_data/res_id/res_err stay stable, until res_ready. No new request is accepted until the cycle after the DONE->IDLE transition (ready is low in DONE).
- Arithmetic (all modulo 2^W):
  - ADD: low W bits of a+b.
  - SUB: a-b, wraps (e.g. 0x00-0x01=0xFF).
  - MUL: low W bits of the 2W-bit product.
  - DIV: unsigned quotient; remainder is discarded.
  - DIV with b==0: res_data=all ones, res_err=1, no EXEC phase.
  - res_err=0 for every other case.
- busy is high in EXEC and DONE.

Decomposition:
- Shared package alu_pkg holds:
  - op encoding constants ADD/SUB/MUL/DIV (2'b00..2'b11);
  - state typedef {IDLE, EXEC, DONE}.
- One natural sub-module, alu_iter_core: the iterative MUL/DIV engine.
  - Interface: start, op, a, b in; done, result out.
  - Holds the shift registers and iteration counter.
- The top level holds the arbiter, FSM and output registers.

Test Plan:
- Reset check: assert rst mid-MUL, release, leave both valid low -> res_valid=0 and busy=0 immediately; no spurious result; next request is served normally.
- Single-cycle ops: req0 ADD a=0xF0 b=0x20 -> res_data=0x10, res_id=0, res_err=0 one cycle after accept. SUB 0x00-0x01 -> 0xFF.
- Multi-cycle ops: req1 MUL 0x0F*0x11 -> 0xFF after W+1 cycles. DIV 200/7 -> 28 (0x1C), res_id=1.
- Divide by zero: DIV a=0x55 b=0 -> res_data=0xFF, res_err=1, result one cycle after accept; busy never enters EXEC.
- Contention: both requesters valid continuously with 4 ops each, res_ready=1 -> grants alternate 0,1,0,1...; res_id sequence matches the grants; ready is never high on both in the same cycle.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_data/res_id stable; both ready low. Raise res_ready -> DONE->IDLE; next accept occurs the following cycle.
